// File: rtl/cfs_algn_pkg.sv
// Aligner shared widths, entry type, config rule and FSM states.
// Used by the core with or without CFS_ALGN_CTRL_STATS_EN.
`define CFS_ALGN_ENTRY_T(DW) struct packed { \
    logic [cfs_algn_pkg::size_w(DW)-1:0]   size; \
    logic [cfs_algn_pkg::offset_w(DW)-1:0] offset; \
    logic [(DW)-1:0]                       data; \
}

package cfs_algn_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } algn_state_e;

    function automatic int offset_w(int dw);
        return (dw <= 8) ? 1 : $clog2(dw / 8);
    endfunction

    function automatic int size_w(int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    function automatic int fifo_w(int dw);
        return dw + offset_w(dw) + size_w(dw);
    endfunction

    // Output window must be non-empty, fit the bus and sit on a size boundary.
    function automatic logic cfg_legal(int off, int size, int b);
        if (size == 0) begin
            return 1'b0;
        end
        return ((off + size) <= b) && ((off % size) == 0);
    endfunction

endpackage

// File: rtl/cfs_algn_ctrl_if.sv
// RX pop / TX push handshake bundle of the aligner core.
// The aligner itself connects through the slave modport.
interface cfs_algn_ctrl_if #(
    parameter int ALGN_DATA_WIDTH = 32
);
    import cfs_algn_pkg::*;

    localparam int FIFO_W = fifo_w(ALGN_DATA_WIDTH);

    logic              rx_pop_valid;
    logic [FIFO_W-1:0] rx_pop_data;
    logic              rx_pop_ready;
    logic              tx_push_valid;
    logic [FIFO_W-1:0] tx_push_data;
    logic              tx_push_ready;

    modport master (
        output rx_pop_valid,
        output rx_pop_data,
        output tx_push_ready,
        input  rx_pop_ready,
        input  tx_push_valid,
        input  tx_push_data
    );

    modport slave (
        input  rx_pop_valid,
        input  rx_pop_data,
        input  tx_push_ready,
        output rx_pop_ready,
        output tx_push_valid,
        output tx_push_data
    );

endinterface

// File: rtl/cfs_algn_byte_buf.sv
// 2B-byte repack buffer: drop n head bytes, then append at the new tail.
// Bytes above cnt are always zero.
module cfs_algn_byte_buf
    import cfs_algn_pkg::*;
#(
    parameter int B = 4,
    localparam int SIZE_W = size_w(8 * B),
    localparam int CNT_W = SIZE_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [SIZE_W-1:0] shift_n,
    input  logic              app_en,
    input  logic [8*B-1:0]    app_data,
    input  logic [SIZE_W-1:0] app_n,
    output logic [8*B-1:0]    head,
    output logic [CNT_W-1:0]  cnt,
    output logic [CNT_W-1:0]  cnt_next
);

    logic [16*B-1:0] store;
    logic [16*B-1:0] kept;
    logic [16*B-1:0] ins;
    logic [CNT_W-1:0] cnt_kept;

    always_comb begin
        cnt_kept = cnt - (shift_en ? CNT_W'(shift_n) : '0);
        kept     = shift_en ? (store >> {shift_n, 3'b000}) : store;
        ins      = '0;
        if (app_en) begin
            ins = {{(8*B){1'b0}}, app_data} << {cnt_kept, 3'b000};
        end
        cnt_next = cnt_kept + (app_en ? CNT_W'(app_n) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store <= '0;
            cnt   <= '0;
        end else begin
            store <= kept | ins;
            cnt   <= cnt_next;
        end
    end

    assign head = store[8*B-1:0];

endmodule

// File: rtl/cfs_algn_ctrl.sv
// Aligner core: repacks RX FIFO entries into ctrl_offset/ctrl_size TX entries.
// CFS_ALGN_CTRL_STATS_EN adds the stat_rx_drop / stat_tx_cnt counters.
module cfs_algn_ctrl
    import cfs_algn_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH = 32,
    localparam int B = ALGN_DATA_WIDTH / 8,
    localparam int OFFSET_W = offset_w(ALGN_DATA_WIDTH),
    localparam int SIZE_W = size_w(ALGN_DATA_WIDTH),
    localparam int CNT_W = SIZE_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OFFSET_W-1:0] ctrl_offset,
    input  logic [SIZE_W-1:0]   ctrl_size,
    cfs_algn_ctrl_if.slave      bus,
    output logic                busy,
    output logic                cfg_err
`ifdef CFS_ALGN_CTRL_STATS_EN
    ,
    output logic [15:0]         stat_rx_drop,
    output logic [15:0]         stat_tx_cnt
`endif
);

    typedef `CFS_ALGN_ENTRY_T(ALGN_DATA_WIDTH) entry_t;

    algn_state_e state;
    algn_state_e state_d;

    logic [OFFSET_W-1:0] cfg_off;
    logic [SIZE_W-1:0]   cfg_size;

    entry_t rx;
    entry_t tx;

    logic [8*B-1:0]   head;
    logic [8*B-1:0]   rx_bytes;
    logic [8*B-1:0]   rx_mask;
    logic [8*B-1:0]   tx_mask;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             rx_legal;
    logic             room;
    logic             pop;
    logic             push;

    assign rx      = bus.rx_pop_data;
    assign cfg_err = !cfg_legal(int'(cfg_off), int'(cfg_size), B);

    // Input side: illegal entries are still popped, just never appended.
    assign rx_legal = (rx.size != '0) &&
                      ((CNT_W'(rx.offset) + CNT_W'(rx.size)) <= CNT_W'(B));
    assign room     = (cnt + CNT_W'(rx.size)) <= CNT_W'(2 * B);
    assign rx_mask  = ~({(8*B){1'b1}} << {rx.size, 3'b000});
    assign rx_bytes = (rx.data >> {rx.offset, 3'b000}) & rx_mask;

    assign bus.rx_pop_ready = bus.rx_pop_valid & !cfg_err & room;
    assign pop              = bus.rx_pop_ready;

    assign tx_mask = ~({(8*B){1'b1}} << {cfg_size, 3'b000});

    always_comb begin
        tx        = '0;
        tx.size   = cfg_size;
        tx.offset = cfg_off;
        tx.data   = (head & tx_mask) << {cfg_off, 3'b000};
    end

    assign bus.tx_push_valid = !cfg_err && (cnt >= CNT_W'(cfg_size));
    assign bus.tx_push_data  = tx;
    assign push              = bus.tx_push_valid & bus.tx_push_ready;
    assign busy              = (cnt != '0);

    cfs_algn_byte_buf #(
        .B (B)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .shift_en (push),
        .shift_n  (cfg_size),
        .app_en   (pop & rx_legal),
        .app_data (rx_bytes),
        .app_n    (rx.size),
        .head     (head),
        .cnt      (cnt),
        .cnt_next (cnt_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:   if (cnt_next != '0) state_d = ACTIVE;
            ACTIVE: if (cnt_next == '0) state_d = IDLE;
        endcase
    end

    // Config tracks ctrl_* only while empty so a TX entry never changes shape.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_off  <= '0;
            cfg_size <= '0;
        end else if (state == IDLE) begin
            cfg_off  <= ctrl_offset;
            cfg_size <= ctrl_size;
        end
    end

`ifdef CFS_ALGN_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rx_drop <= '0;
            stat_tx_cnt  <= '0;
        end else begin
            if (pop && !rx_legal && (stat_rx_drop != 16'hFFFF)) begin
                stat_rx_drop <= stat_rx_drop + 16'd1;
            end
            if (push && (stat_tx_cnt != 16'hFFFF)) begin
                stat_tx_cnt <= stat_tx_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cfs_algn_ctrl.sv
// Bench for cfs_algn_ctrl at B=4: directed cases plus random traffic
// checked against a byte-queue reference model.
module tb_cfs_algn_ctrl;
    import cfs_algn_pkg::*;

    localparam int DW = 32;
    localparam int B  = DW / 8;
    localparam int FW = fifo_w(DW);

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ctrl_offset;
    logic [2:0] ctrl_size;
    logic       busy;
    logic       cfg_err;
`ifdef CFS_ALGN_CTRL_STATS_EN
    logic [15:0] stat_rx_drop;
    logic [15:0] stat_tx_cnt;
`endif

    cfs_algn_ctrl_if #(.ALGN_DATA_WIDTH(DW)) bus ();

    cfs_algn_ctrl #(
        .ALGN_DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_offset  (ctrl_offset),
        .ctrl_size    (ctrl_size),
        .bus          (bus),
        .busy         (busy),
        .cfg_err      (cfg_err)
`ifdef CFS_ALGN_CTRL_STATS_EN
        ,
        .stat_rx_drop (stat_rx_drop),
        .stat_tx_cnt  (stat_tx_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    int m_off;
    int m_size;
    int m_drop;
    int m_txc;
    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_cfg(int o, int s);
        if (s == 0) return 1'b0;
        return (o + s <= B) && (o % s == 0);
    endfunction

    function automatic logic [FW-1:0] ent(int s, int o, logic [31:0] d);
        return {3'(s), 2'(o), d};
    endfunction

    // One clock: drive at negedge, compare against the model, update at posedge.
    task automatic step(input logic v, input logic [FW-1:0] e,
                        input logic rdy, input int co, input int cs,
                        input logic rst, output logic [FW-1:0] txd,
                        output logic prd, output logic bsy);
        int sz;
        int of;
        bit ok;
        bit e_ok;
        bit e_pop;
        bit e_push;
        bit was_idle;
        logic [31:0] d;
        @(negedge clk);
        reset             = rst;
        bus.rx_pop_valid  = v;
        bus.rx_pop_data   = e;
        bus.tx_push_ready = rdy;
        ctrl_offset       = 2'(co);
        ctrl_size         = 3'(cs);
        #1;
        sz     = int'(e[36:34]);
        of     = int'(e[33:32]);
        ok     = legal_cfg(m_off, m_size);
        e_ok   = (sz > 0) && (of + sz <= B);
        e_pop  = v && ok && (q.size() + sz <= 2 * B);
        e_push = ok && (q.size() >= m_size);
        d      = '0;
        if (e_push) begin
            for (int k = 0; k < m_size; k++) d[8*(m_off+k) +: 8] = q[k];
        end
        check("rx_pop_ready", 64'(bus.rx_pop_ready), 64'(e_pop));
        check("tx_push_valid", 64'(bus.tx_push_valid), 64'(e_push));
        if (e_push) begin
            check("tx_push_data", 64'(bus.tx_push_data),
                  64'({3'(m_size), 2'(m_off), d}));
        end
        check("busy", 64'(busy), 64'(q.size() != 0));
        check("cfg_err", 64'(cfg_err), 64'(!ok));
`ifdef CFS_ALGN_CTRL_STATS_EN
        check("stat_rx_drop", 64'(stat_rx_drop), 64'(m_drop));
        check("stat_tx_cnt", 64'(stat_tx_cnt), 64'(m_txc));
`endif
        txd = bus.tx_push_data;
        prd = bus.rx_pop_ready;
        bsy = busy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_off  = 0;
            m_size = 0;
            m_drop = 0;
            m_txc  = 0;
        end else begin
            was_idle = (q.size() == 0);
            if (e_push && rdy) begin
                repeat (m_size) void'(q.pop_front());
                if (m_txc < 65535) m_txc++;
            end
            if (e_pop) begin
                if (e_ok) begin
                    for (int k = 0; k < sz; k++) q.push_back(e[8*(of+k) +: 8]);
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (was_idle) begin
                m_off  = co;
                m_size = cs;
            end
        end
    endtask

    initial begin
        logic [FW-1:0] txd;
        logic prd;
        logic bsy;
        int lo[8] = '{0, 1, 2, 3, 0, 2, 0, 0};
        int ls[8] = '{1, 1, 1, 1, 2, 2, 3, 4};
        int co;
        int cs;
        int s;
        int o;
        int j;
        n_tests = 0;
        n_fail  = 0;
        reset             = 1'b1;
        bus.rx_pop_valid  = 1'b0;
        bus.rx_pop_data   = '0;
        bus.tx_push_ready = 1'b0;
        ctrl_offset       = '0;
        ctrl_size         = '0;
        q.delete();
        m_off  = 0;
        m_size = 0;
        m_drop = 0;
        m_txc  = 0;

        step(0, '0, 0, 0, 4, 1, txd, prd, bsy);
        step(0, '0, 0, 0, 4, 0, txd, prd, bsy);
        check("reset_tx_data", 64'(txd), 64'd0);

        // merge
        step(1, ent(2, 0, 32'h0000BBAA), 0, 0, 4, 0, txd, prd, bsy);
        step(1, ent(2, 2, 32'hDDCC0000), 0, 0, 4, 0, txd, prd, bsy);
        step(0, '0, 1, 0, 4, 0, txd, prd, bsy);
        check("merge", 64'(txd), 64'(ent(4, 0, 32'hDDCCBBAA)));

        // split
        step(0, '0, 0, 2, 2, 0, txd, prd, bsy);
        step(1, ent(4, 0, 32'h44332211), 0, 2, 2, 0, txd, prd, bsy);
        step(0, '0, 1, 2, 2, 0, txd, prd, bsy);
        check("split0", 64'(txd), 64'(ent(2, 2, 32'h22110000)));
        step(0, '0, 1, 2, 2, 0, txd, prd, bsy);
        check("split1", 64'(txd), 64'(ent(2, 2, 32'h44330000)));

        // backpressure and full buffer
        step(0, '0, 0, 3, 1, 0, txd, prd, bsy);
        step(1, ent(4, 0, 32'h44332211), 0, 3, 1, 0, txd, prd, bsy);
        step(1, ent(4, 0, 32'h88776655), 0, 3, 1, 0, txd, prd, bsy);
        check("bp_first", 64'(txd), 64'(ent(1, 3, 32'h11000000)));
        step(1, ent(4, 0, 32'hCCBBAA99), 0, 3, 1, 0, txd, prd, bsy);
        check("bp_full_block", 64'(prd), 64'd0);
        check("bp_hold", 64'(txd), 64'(ent(1, 3, 32'h11000000)));
        repeat (8) step(0, '0, 1, 3, 1, 0, txd, prd, bsy);
        step(0, '0, 0, 3, 1, 0, txd, prd, bsy);
        check("bp_drained", 64'(bsy), 64'd0);

        // config frozen while active
        step(0, '0, 0, 0, 2, 0, txd, prd, bsy);
        step(1, ent(4, 0, 32'h44332211), 0, 0, 2, 0, txd, prd, bsy);
        step(0, '0, 1, 0, 1, 0, txd, prd, bsy);
        check("frz0", 64'(txd), 64'(ent(2, 0, 32'h00002211)));
        step(0, '0, 1, 0, 1, 0, txd, prd, bsy);
        check("frz1", 64'(txd), 64'(ent(2, 0, 32'h00004433)));
        step(0, '0, 0, 0, 1, 0, txd, prd, bsy);
        step(1, ent(1, 0, 32'h00000055), 0, 0, 1, 0, txd, prd, bsy);
        step(0, '0, 1, 0, 1, 0, txd, prd, bsy);
        check("frz_new", 64'(txd), 64'(ent(1, 0, 32'h00000055)));

        // illegal config
        step(0, '0, 0, 1, 2, 0, txd, prd, bsy);
        step(1, ent(4, 0, 32'h01020304), 1, 1, 2, 0, txd, prd, bsy);
        check("cfg_illegal_pop", 64'(prd), 64'd0);

        // illegal input entries
        step(0, '0, 0, 0, 4, 0, txd, prd, bsy);
        step(1, ent(0, 0, 32'hDEADBEEF), 0, 0, 4, 0, txd, prd, bsy);
        check("bad_rx0_pop", 64'(prd), 64'd1);
        step(1, ent(3, 2, 32'hCAFEF00D), 0, 0, 4, 0, txd, prd, bsy);
        check("bad_rx1_pop", 64'(prd), 64'd1);
        step(0, '0, 0, 0, 4, 0, txd, prd, bsy);
        check("bad_rx_busy", 64'(bsy), 64'd0);

        // reset with bytes held
        step(1, ent(3, 0, 32'h00CCBBAA), 0, 0, 4, 0, txd, prd, bsy);
        step(0, '0, 0, 0, 4, 1, txd, prd, bsy);
        step(0, '0, 0, 0, 4, 0, txd, prd, bsy);
        check("rst_busy", 64'(bsy), 64'd0);
        step(1, ent(4, 0, 32'h04030201), 0, 0, 4, 0, txd, prd, bsy);
        step(0, '0, 1, 0, 4, 0, txd, prd, bsy);
        check("rst_after", 64'(txd), 64'(ent(4, 0, 32'h04030201)));

        // random traffic
        co = 0;
        cs = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 4) == 0) begin
                    co = int'($urandom_range(0, 3));
                    cs = int'($urandom_range(0, 7));
                end else begin
                    j  = int'($urandom_range(0, 7));
                    co = lo[j];
                    cs = ls[j];
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                s = int'($urandom_range(0, 7));
                o = int'($urandom_range(0, 3));
            end else begin
                s = int'($urandom_range(1, 4));
                o = int'($urandom_range(0, 4 - s));
            end
            step($urandom_range(0, 3) != 0, ent(s, o, $urandom),
                 $urandom_range(0, 3) != 0, co, cs,
                 $urandom_range(0, 199) == 0, txd, prd, bsy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
